// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the writeback path and, later, the LSU.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: MEM results and pipeline control in, WB writeback and counter out.
interface mem_wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_out;
  logic [XLEN-1:0] mem_read_data;
  logic [XLEN-1:0] mem_pc4;
  logic [4:0]      mem_rd;
  logic            mem_reg_write;
  logic [1:0]      mem_wb_sel;
  logic [2:0]      mem_funct3;
  logic            stall;
  logic            flush;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic [XLEN-1:0] wb_data;
  logic            wb_misaligned;
  logic [CNT_W-1:0] instret;

  modport master (
    output mem_valid, mem_alu_out, mem_read_data, mem_pc4, mem_rd,
           mem_reg_write, mem_wb_sel, mem_funct3, stall, flush,
    input  wb_valid, wb_rd, wb_we, wb_data, wb_misaligned, instret
  );

  modport slave (
    input  mem_valid, mem_alu_out, mem_read_data, mem_pc4, mem_rd,
           mem_reg_write, mem_wb_sel, mem_funct3, stall, flush,
    output wb_valid, wb_rd, wb_we, wb_data, wb_misaligned, instret
  );
endinterface

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/half from a word-aligned
// DMEM read, extends it, and flags misaligned halfword/word accesses.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ext_s;

  // lane select, extension and misalignment decode
  always_comb begin
    byte_s = word[7:0];
    case (addr)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase

    if (addr[1]) half_s = word[31:16];
    else         half_s = word[15:0];

    ext_s      = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  ext_s = sext8(byte_s);
      F3_LBU: ext_s = {24'h000000, byte_s};
      F3_LH: begin
        ext_s      = sext16(half_s);
        misaligned = addr[0];
      end
      F3_LHU: begin
        ext_s      = {16'h0000, half_s};
        misaligned = addr[0];
      end
      // LW and the undefined encodings all take the full word
      default: begin
        ext_s      = word;
        misaligned = (addr != 2'b00);
      end
    endcase

    data = misaligned ? 32'h0000_0000 : ext_s;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: forms the regfile write value, registers it with
// stall/flush control, and counts retired instructions.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);

  logic [XLEN-1:0]  ld_data_s;
  logic             ld_mis_s;
  logic             mis_s;
  logic             we_s;
  logic [XLEN-1:0]  data_s;

  logic             wb_valid_d, wb_valid_q;
  logic [4:0]       wb_rd_d, wb_rd_q;
  logic             wb_we_d, wb_we_q;
  logic [XLEN-1:0]  wb_data_d, wb_data_q;
  logic             wb_mis_d, wb_mis_q;
  logic [CNT_W-1:0] instret_d, instret_q;

  load_align u_load_align (
    .word       (bus.mem_read_data),
    .addr       (bus.mem_alu_out[1:0]),
    .funct3     (bus.mem_funct3),
    .data       (ld_data_s),
    .misaligned (ld_mis_s)
  );

  // writeback value and qualified write enable for the instruction in MEM
  always_comb begin
    mis_s = (bus.mem_wb_sel == WB_SEL_LOAD) & ld_mis_s;
    case (bus.mem_wb_sel)
      WB_SEL_ALU:  data_s = bus.mem_alu_out;
      WB_SEL_LOAD: data_s = ld_data_s;
      WB_SEL_PC4:  data_s = bus.mem_pc4;
      default:     data_s = bus.mem_alu_out;
    endcase
    we_s = bus.mem_valid & bus.mem_reg_write & (bus.mem_rd != 5'd0) & ~mis_s;
  end

  // next WB state: flush beats stall beats capture; the retiring entry counts on capture
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    wb_mis_d   = wb_mis_q;
    instret_d  = instret_q;
    if (bus.flush) begin
      wb_valid_d = 1'b0;
      wb_rd_d    = 5'd0;
      wb_we_d    = 1'b0;
      wb_data_d  = {XLEN{1'b0}};
      wb_mis_d   = 1'b0;
      instret_d  = instret_q;
    end else if (bus.stall) begin
      instret_d  = instret_q;
    end else begin
      wb_valid_d = bus.mem_valid;
      wb_rd_d    = bus.mem_rd;
      wb_we_d    = we_s;
      wb_data_d  = data_s;
      wb_mis_d   = mis_s;
      instret_d  = instret_q + {{(CNT_W-1){1'b0}}, wb_valid_q};
    end
  end

  // WB register bank and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= {XLEN{1'b0}};
      wb_mis_q   <= 1'b0;
      instret_q  <= {CNT_W{1'b0}};
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      wb_mis_q   <= wb_mis_d;
      instret_q  <= instret_d;
    end
  end

  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_we         = wb_we_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_misaligned = wb_mis_q;
  assign bus.instret       = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed spec scenarios plus randomized traffic against a reference model.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(32), .CNT_W(32)) ifc ();
  mem_wb_stage_if #(.XLEN(32), .CNT_W(4))  ifw ();

  mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(ifc));
  mem_wb_stage #(.XLEN(32), .CNT_W(4))  dut_w (.clk(clk), .rst(rst), .bus(ifw));

  // the narrow-counter instance sees the same stream
  assign ifw.mem_valid     = ifc.mem_valid;
  assign ifw.mem_alu_out   = ifc.mem_alu_out;
  assign ifw.mem_read_data = ifc.mem_read_data;
  assign ifw.mem_pc4       = ifc.mem_pc4;
  assign ifw.mem_rd        = ifc.mem_rd;
  assign ifw.mem_reg_write = ifc.mem_reg_write;
  assign ifw.mem_wb_sel    = ifc.mem_wb_sel;
  assign ifw.mem_funct3    = ifc.mem_funct3;
  assign ifw.stall         = ifc.stall;
  assign ifw.flush         = ifc.flush;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        mis;
  } wb_t;

  wb_t         exp_wb;
  logic [31:0] exp_cnt;

  // what the instruction currently in MEM should become in WB
  function automatic wb_t form();
    wb_t r;
    int size, a, off;
    logic [31:0] raw, mask;
    size = (ifc.mem_funct3[1:0] == 2'b00) ? 1 : (ifc.mem_funct3[1:0] == 2'b01) ? 2 : 4;
    a    = int'(ifc.mem_alu_out[1:0]);
    off  = a - (a % size);
    raw  = ifc.mem_read_data >> (8 * off);
    if (size < 4) begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      raw  = raw & mask;
      if (!ifc.mem_funct3[2] && raw[8*size-1]) raw = raw | ~mask;
    end
    r.mis = (ifc.mem_wb_sel == 2'd1) && ((a % size) != 0);
    if (ifc.mem_wb_sel == 2'd1)      r.data = r.mis ? 32'h0 : raw;
    else if (ifc.mem_wb_sel == 2'd2) r.data = ifc.mem_pc4;
    else                             r.data = ifc.mem_alu_out;
    r.valid = ifc.mem_valid;
    r.rd    = ifc.mem_rd;
    r.we    = ifc.mem_valid && ifc.mem_reg_write && (ifc.mem_rd != 5'd0) && !r.mis;
    return r;
  endfunction

  // advance one clock, updating the model from the pre-edge inputs
  task automatic step();
    wb_t nxt;
    logic [31:0] ncnt;
    nxt  = exp_wb;
    ncnt = exp_cnt;
    if (rst) begin
      nxt  = '0;
      ncnt = 32'd0;
    end else if (ifc.flush) begin
      nxt = '0;
    end else if (!ifc.stall) begin
      nxt  = form();
      ncnt = exp_cnt + (exp_wb.valid ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    exp_wb  = nxt;
    exp_cnt = ncnt;
  endtask

  task automatic set_op(input logic v, input logic [31:0] alu, input logic [31:0] word,
                        input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                        input logic [1:0] sel, input logic [2:0] f3);
    ifc.mem_valid     = v;
    ifc.mem_alu_out   = alu;
    ifc.mem_read_data = word;
    ifc.mem_pc4       = pc4;
    ifc.mem_rd        = rd;
    ifc.mem_reg_write = rw;
    ifc.mem_wb_sel    = sel;
    ifc.mem_funct3    = f3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(1'b1, 32'hAAAA_0000, 32'h5555_5555, 32'h10, 5'd3, 1'b1, 2'd0, 3'b010);
    step();
    step();
    checks += 7;
    if (ifc.wb_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid got %0h want 0", ifc.wb_valid); end
    if (ifc.wb_rd !== 5'd0)         begin errors++; $display("FAIL reset_rd got %0h want 0", ifc.wb_rd); end
    if (ifc.wb_we !== 1'b0)         begin errors++; $display("FAIL reset_we got %0h want 0", ifc.wb_we); end
    if (ifc.wb_data !== 32'd0)      begin errors++; $display("FAIL reset_data got %0h want 0", ifc.wb_data); end
    if (ifc.wb_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %0h want 0", ifc.wb_misaligned); end
    if (ifc.instret !== 32'd0)      begin errors++; $display("FAIL reset_instret got %0h want 0", ifc.instret); end
    if (ifw.instret !== 4'd0)       begin errors++; $display("FAIL reset_instret_w got %0h want 0", ifw.instret); end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    set_op(1'b1, 32'h0000_1003, 32'h80FF_1234, 32'h0, 5'd5, 1'b1, 2'd1, 3'b000);
    step();
    checks += 3;
    if (ifc.wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", ifc.wb_data); end
    if (ifc.wb_we !== 1'b1)            begin errors++; $display("FAIL lb_we got %0h want 1", ifc.wb_we); end
    if (ifc.wb_rd !== 5'd5)            begin errors++; $display("FAIL lb_rd got %0d want 5", ifc.wb_rd); end
    set_op(1'b1, 32'h0000_2002, 32'hBEEF_0000, 32'h0, 5'd6, 1'b1, 2'd1, 3'b101);
    step();
    checks += 2;
    if (ifc.wb_data !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got %h want 0000beef", ifc.wb_data); end
    if (ifc.wb_misaligned !== 1'b0)    begin errors++; $display("FAIL lhu_mis got %0h want 0", ifc.wb_misaligned); end
    set_op(1'b1, 32'h0000_2001, 32'hBEEF_0000, 32'h0, 5'd6, 1'b1, 2'd1, 3'b001);
    step();
    checks += 3;
    if (ifc.wb_misaligned !== 1'b1) begin errors++; $display("FAIL lh_mis got %0h want 1", ifc.wb_misaligned); end
    if (ifc.wb_we !== 1'b0)         begin errors++; $display("FAIL lh_mis_we got %0h want 0", ifc.wb_we); end
    if (ifc.wb_valid !== 1'b1)      begin errors++; $display("FAIL lh_mis_valid got %0h want 1", ifc.wb_valid); end
  endtask

  task automatic test_jal_x0();
    set_op(1'b1, 32'h0000_0F00, 32'h0, 32'h0000_0104, 5'd1, 1'b1, 2'd2, 3'b000);
    step();
    checks += 2;
    if (ifc.wb_data !== 32'h0000_0104) begin errors++; $display("FAIL jal_data got %h want 00000104", ifc.wb_data); end
    if (ifc.wb_we !== 1'b1)            begin errors++; $display("FAIL jal_we got %0h want 1", ifc.wb_we); end
    set_op(1'b1, 32'h0000_0042, 32'h0, 32'h0, 5'd0, 1'b1, 2'd0, 3'b000);
    step();
    checks += 3;
    if (ifc.wb_we !== 1'b0)            begin errors++; $display("FAIL x0_we got %0h want 0", ifc.wb_we); end
    if (ifc.wb_valid !== 1'b1)         begin errors++; $display("FAIL x0_valid got %0h want 1", ifc.wb_valid); end
    if (ifc.wb_data !== 32'h0000_0042) begin errors++; $display("FAIL x0_data got %h want 00000042", ifc.wb_data); end
  endtask

  task automatic test_stall();
    logic [31:0] cnt0;
    set_op(1'b1, 32'h1234_5678, 32'h0, 32'h0, 5'd7, 1'b1, 2'd0, 3'b000);
    step();
    cnt0 = exp_cnt;
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, $urandom, $urandom, $urandom, 5'd9, 1'b1, 2'd0, 3'b000);
      step();
      checks += 3;
      if (ifc.wb_data !== 32'h1234_5678) begin errors++; $display("FAIL stall_data cyc%0d got %h want 12345678", i, ifc.wb_data); end
      if (ifc.wb_rd !== 5'd7)            begin errors++; $display("FAIL stall_rd cyc%0d got %0d want 7", i, ifc.wb_rd); end
      if (ifc.instret !== cnt0)          begin errors++; $display("FAIL stall_instret cyc%0d got %0d want %0d", i, ifc.instret, cnt0); end
    end
    ifc.stall = 1'b0;
    ifc.mem_valid = 1'b0;
    step();
    checks += 2;
    if (ifc.instret !== cnt0 + 32'd1) begin errors++; $display("FAIL release_instret got %0d want %0d", ifc.instret, cnt0 + 32'd1); end
    if (ifc.wb_valid !== 1'b0)        begin errors++; $display("FAIL release_valid got %0h want 0", ifc.wb_valid); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] cnt0;
    set_op(1'b1, 32'h0000_0055, 32'h0, 32'h0, 5'd4, 1'b1, 2'd0, 3'b000);
    step();
    cnt0 = exp_cnt;
    ifc.stall = 1'b1;
    ifc.flush = 1'b1;
    step();
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;
    checks += 4;
    if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h want 0", ifc.wb_valid); end
    if (ifc.wb_we !== 1'b0)    begin errors++; $display("FAIL flush_we got %0h want 0", ifc.wb_we); end
    if (ifc.wb_data !== 32'd0) begin errors++; $display("FAIL flush_data got %h want 0", ifc.wb_data); end
    if (ifc.instret !== cnt0)  begin errors++; $display("FAIL flush_instret got %0d want %0d", ifc.instret, cnt0); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, $urandom, $urandom, $urandom, 5'd12, 1'b1, 2'd0, 3'b010);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 4;
    if (ifc.wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0h want 0", ifc.wb_valid); end
    if (ifc.wb_we !== 1'b0)    begin errors++; $display("FAIL rstmid_we got %0h want 0", ifc.wb_we); end
    if (ifc.wb_rd !== 5'd0)    begin errors++; $display("FAIL rstmid_rd got %0d want 0", ifc.wb_rd); end
    if (ifc.instret !== 32'd0) begin errors++; $display("FAIL rstmid_instret got %0d want 0", ifc.instret); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_op(1'b1, $urandom, 32'h0, 32'h0, 5'd2, 1'b1, 2'd0, 3'b000);
      step();
    end
    checks += 2;
    if (ifw.instret !== 4'd0)   begin errors++; $display("FAIL wrap_instret_w got %0d want 0", ifw.instret); end
    if (ifc.instret !== 32'd16) begin errors++; $display("FAIL wrap_instret got %0d want 16", ifc.instret); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_op(1'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
             1'($urandom), 2'($urandom), 3'($urandom));
      ifc.stall = ($urandom_range(0, 5) == 0);
      ifc.flush = ($urandom_range(0, 9) == 0);
      step();
      checks += 7;
      if (ifc.wb_valid !== exp_wb.valid)    begin errors++; $display("FAIL rnd_valid cyc%0d got %0h want %0h", i, ifc.wb_valid, exp_wb.valid); end
      if (ifc.wb_rd !== exp_wb.rd)          begin errors++; $display("FAIL rnd_rd cyc%0d got %0d want %0d", i, ifc.wb_rd, exp_wb.rd); end
      if (ifc.wb_we !== exp_wb.we)          begin errors++; $display("FAIL rnd_we cyc%0d got %0h want %0h", i, ifc.wb_we, exp_wb.we); end
      if (ifc.wb_data !== exp_wb.data)      begin errors++; $display("FAIL rnd_data cyc%0d got %h want %h", i, ifc.wb_data, exp_wb.data); end
      if (ifc.wb_misaligned !== exp_wb.mis) begin errors++; $display("FAIL rnd_mis cyc%0d got %0h want %0h", i, ifc.wb_misaligned, exp_wb.mis); end
      if (ifc.instret !== exp_cnt)          begin errors++; $display("FAIL rnd_instret cyc%0d got %0d want %0d", i, ifc.instret, exp_cnt); end
      if (ifw.instret !== exp_cnt[3:0])     begin errors++; $display("FAIL rnd_instret_w cyc%0d got %0d want %0d", i, ifw.instret, exp_cnt[3:0]); end
    end
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;
  endtask

  initial begin
    exp_wb  = '0;
    exp_cnt = 32'd0;
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;
    set_op(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 3'b000);
    test_reset();
    test_loads();
    test_jal_x0();
    test_stall();
    test_stall_flush();
    test_rst_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
